// File: rtl/frame_buffer_scheduler_if.sv
// Capture-side and reader-side signals of the ping-pong frame-buffer scheduler.
// The master drives requests and pixel events; the slave is the scheduler.
interface frame_buffer_scheduler_if #(
    parameter int ADDR_W = 20
);
    logic              init_done;
    logic              wr_frame_start;
    logic              wr_frame_end;
    logic              wr_pix_valid;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_active;
    logic              rd_req;
    logic              rd_grant;
    logic              rd_buf;
    logic [ADDR_W-1:0] rd_base_addr;
    logic              rd_done;
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;

    modport master (
        output init_done, wr_frame_start, wr_frame_end, wr_pix_valid, rd_req, rd_done,
        input  wr_we, wr_addr, wr_active, rd_grant, rd_buf, rd_base_addr, frame_cnt, err_cnt
    );

    modport slave (
        input  init_done, wr_frame_start, wr_frame_end, wr_pix_valid, rd_req, rd_done,
        output wr_we, wr_addr, wr_active, rd_grant, rd_buf, rd_base_addr, frame_cnt, err_cnt
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame-buffer manager: assigns camera frames to one of two buffers,
// generates write addresses and hands the newest complete frame to the reader.
module frame_buffer_scheduler #(
    parameter int ADDR_W      = 20,
    parameter int FRAME_WORDS = 50176,
    parameter int BUF0_BASE   = 0,
    parameter int BUF1_BASE   = 65536
) (
    input logic                     clk,
    input logic                     rst_n,
    frame_buffer_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_WRITING,
        BUF_READY,
        BUF_READING
    } buf_state_t;

    localparam logic [15:0]       FRAME_LEN = 16'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(BUF0_BASE);
    localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(BUF1_BASE);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    buf_state_t        buf_st [2];
    buf_state_t        st_nxt [2];
    logic              newest, newest_nxt;
    logic              cur, cur_nxt;
    logic              active, active_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              pix_we, frame_ok, frame_bad;
    logic              grant, grant_idx, reading_any, tgt;
    logic              start_eff;

    logic              wr_we_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              rd_grant_r;
    logic              rd_buf_r;
    logic [ADDR_W-1:0] rd_base_r;
    logic [7:0]        frame_cnt_r;
    logic [7:0]        err_cnt_r;

    assign start_eff   = bus.wr_frame_start & bus.init_done;
    assign reading_any = (buf_st[0] == BUF_READING) || (buf_st[1] == BUF_READING);

    always_comb begin
        st_nxt     = buf_st;
        newest_nxt = newest;
        cur_nxt    = cur;
        active_nxt = active;
        cnt_nxt    = cnt;
        pix_we     = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        grant      = 1'b0;
        grant_idx  = newest;
        tgt        = 1'b0;

        // Grant looks only at registered state; a newest pointer left on a
        // buffer that was recycled falls back to the other READY buffer.
        if (bus.rd_req && !reading_any) begin
            if (buf_st[newest] == BUF_READY) begin
                grant     = 1'b1;
                grant_idx = newest;
            end else if (buf_st[~newest] == BUF_READY) begin
                grant     = 1'b1;
                grant_idx = ~newest;
            end
        end

        if (bus.rd_done) begin
            for (int i = 0; i < 2; i++) begin
                if (buf_st[i] == BUF_READING) st_nxt[i] = BUF_FREE;
            end
        end

        // A pixel coinciding with a frame boundary is not part of either frame.
        if (active && bus.wr_pix_valid && !bus.wr_frame_end && !start_eff &&
            (cnt < FRAME_LEN)) begin
            pix_we  = 1'b1;
            cnt_nxt = cnt + 16'd1;
        end

        if (active && bus.wr_frame_end) begin
            if (cnt == FRAME_LEN) begin
                st_nxt[cur] = BUF_READY;
                newest_nxt  = cur;
                frame_ok    = 1'b1;
            end else begin
                st_nxt[cur] = BUF_FREE;
                frame_bad   = 1'b1;
            end
            active_nxt = 1'b0;
        end

        // The buffer granted this cycle is already off-limits to the writer.
        if (grant) st_nxt[grant_idx] = BUF_READING;

        if (start_eff) begin
            if (active_nxt) begin
                st_nxt[cur] = BUF_FREE;
                frame_bad   = 1'b1;
            end
            if (st_nxt[0] == BUF_FREE)                                tgt = 1'b0;
            else if (st_nxt[1] == BUF_FREE)                           tgt = 1'b1;
            else if (st_nxt[0] == BUF_READY && newest_nxt != 1'b0)    tgt = 1'b0;
            else if (st_nxt[1] == BUF_READY && newest_nxt != 1'b1)    tgt = 1'b1;
            else if (st_nxt[0] == BUF_READY)                          tgt = 1'b0;
            else                                                      tgt = 1'b1;
            st_nxt[tgt] = BUF_WRITING;
            cur_nxt     = tgt;
            cnt_nxt     = 16'd0;
            active_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_st[0]   <= BUF_FREE;
            buf_st[1]   <= BUF_FREE;
            newest      <= 1'b0;
            cur         <= 1'b0;
            active      <= 1'b0;
            cnt         <= 16'd0;
            wr_we_r     <= 1'b0;
            wr_addr_r   <= '0;
            rd_grant_r  <= 1'b0;
            rd_buf_r    <= 1'b0;
            rd_base_r   <= BASE0;
            frame_cnt_r <= 8'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            buf_st     <= st_nxt;
            newest     <= newest_nxt;
            cur        <= cur_nxt;
            active     <= active_nxt;
            cnt        <= cnt_nxt;
            wr_we_r    <= pix_we;
            if (pix_we) wr_addr_r <= (cur ? BASE1 : BASE0) + ADDR_W'(cnt);
            rd_grant_r <= grant;
            if (grant) begin
                rd_buf_r  <= grant_idx;
                rd_base_r <= grant_idx ? BASE1 : BASE0;
            end
            if (frame_ok)  frame_cnt_r <= frame_cnt_r + 8'd1;
            if (frame_bad) err_cnt_r   <= sat_inc8(err_cnt_r);
        end
    end

    assign bus.wr_we        = wr_we_r;
    assign bus.wr_addr      = wr_addr_r;
    assign bus.wr_active    = active;
    assign bus.rd_grant     = rd_grant_r;
    assign bus.rd_buf       = rd_buf_r;
    assign bus.rd_base_addr = rd_base_r;
    assign bus.frame_cnt    = frame_cnt_r;
    assign bus.err_cnt      = err_cnt_r;
endmodule
